calc_host_seq: RTL and testbench

- Initiator side of the compute unit's start/pronto control handshake; issues jobs to the control/datapath pair and collects the results.
- Accepts operands from an upstream valid/ready stream and drives the operand bus.
- Pulses start, waits for a fresh pronto, captures the result and presents it downstream on a valid/ready stream.
- Sits between the system bus adapter and the compute unit (control block plus datapath).

---
 rtl/calc_pkg.sv | 12 +
 rtl/calc_host_seq_if.sv | 31 +++
 rtl/calc_wait_timer.sv | 36 +++
 rtl/calc_host_seq.sv | 99 +++++++++
 tb/tb_calc_host_seq.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// Shared types and default widths for the calc compute unit and its host sequencer.
package calc_pkg;
  localparam int CALC_DATA_W = 8;
  localparam int CALC_RES_W  = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    HOLD   = 2'd3
  } calc_host_state_t;
endpackage

// File: rtl/calc_host_seq_if.sv
// Operand stream, start/pronto handshake and result stream of the calc host sequencer.
// master = the sequencer (initiator), slave = upstream/compute unit/downstream side.
interface calc_host_seq_if
  import calc_pkg::*;
#(
  parameter int DATA_W = CALC_DATA_W,
  parameter int RES_W  = CALC_RES_W
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_x;
  logic [DATA_W-1:0] calc_x;
  logic              calc_start;
  logic              calc_pronto;
  logic [RES_W-1:0]  calc_result;
  logic              out_valid;
  logic              out_ready;
  logic [RES_W-1:0]  out_result;
  logic              out_err;
  logic              busy;

  modport master (
    input  in_valid, in_x, calc_pronto, calc_result, out_ready,
    output in_ready, calc_x, calc_start, out_valid, out_result, out_err, busy
  );

  modport slave (
    output in_valid, in_x, calc_pronto, calc_result, out_ready,
    input  in_ready, calc_x, calc_start, out_valid, out_result, out_err, busy
  );
endinterface

// File: rtl/calc_wait_timer.sv
// WAIT-phase bookkeeping: saturating cycle counter and the pronto arm flag.
// Used only when CALC_HOST_TIMEOUT_EN is defined.
module calc_wait_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  input  logic pronto_i,
  output logic armed_o,
  output logic expired_o
);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             armed_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else if (clear_i) begin
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else if (en_i) begin
      // a low pronto proves the previous job's done level has dropped
      if (!pronto_i) armed_q <= 1'b1;
      if (cnt_q != LAST) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign armed_o   = armed_q;
  assign expired_o = en_i && (cnt_q == LAST);
endmodule

// File: rtl/calc_host_seq.sv
// Host sequencer: accepts an operand, pulses calc_start, waits for a fresh pronto,
// then holds the result for downstream. CALC_HOST_TIMEOUT_EN enables the WAIT abort.
module calc_host_seq
  import calc_pkg::*;
#(
  parameter int DATA_W  = CALC_DATA_W,
  parameter int RES_W   = CALC_RES_W,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst,
  calc_host_seq_if.master bus
);
  calc_host_state_t  state_q;
  logic [DATA_W-1:0] x_q;
  logic [RES_W-1:0]  res_q;
  logic              armed;
  logic              take;

`ifdef CALC_HOST_TIMEOUT_EN
  logic err_q;
  logic expired;

  calc_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (state_q == LAUNCH),
    .en_i      (state_q == WAIT),
    .pronto_i  (bus.calc_pronto),
    .armed_o   (armed),
    .expired_o (expired)
  );
`else
  logic armed_q;
  assign armed = armed_q;
`endif

  assign take = armed && bus.calc_pronto;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      res_q   <= '0;
`ifdef CALC_HOST_TIMEOUT_EN
      err_q   <= 1'b0;
`else
      armed_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (bus.in_valid) begin
          x_q     <= bus.in_x;
          state_q <= LAUNCH;
        end
        LAUNCH: begin
`ifndef CALC_HOST_TIMEOUT_EN
          armed_q <= 1'b0;
`endif
          state_q <= WAIT;
        end
        WAIT: begin
`ifndef CALC_HOST_TIMEOUT_EN
          if (!bus.calc_pronto) armed_q <= 1'b1;
`endif
          if (take) begin
            res_q   <= bus.calc_result;
`ifdef CALC_HOST_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
            state_q <= HOLD;
          end
`ifdef CALC_HOST_TIMEOUT_EN
          else if (expired) begin
            res_q   <= '0;
            err_q   <= 1'b1;
            state_q <= HOLD;
          end
`endif
        end
        HOLD: if (bus.out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // handshake outputs are forced quiet for the whole reset cycle
  assign bus.in_ready   = !rst && (state_q == IDLE);
  assign bus.calc_start = !rst && (state_q == LAUNCH);
  assign bus.out_valid  = !rst && (state_q == HOLD);
  assign bus.busy       = !rst && (state_q != IDLE);
  assign bus.calc_x     = x_q;
  assign bus.out_result = res_q;
`ifdef CALC_HOST_TIMEOUT_EN
  assign bus.out_err    = err_q;
`else
  assign bus.out_err    = 1'b0;
`endif
endmodule

// File: tb/tb_calc_host_seq.sv
// Bench for calc_host_seq: directed vector table, reset corner cases and random jobs
// against a job-level model. Timeout vectors run when CALC_HOST_TIMEOUT_EN is defined.
module tb_calc_host_seq;
  localparam int T = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  calc_host_seq_if #(.DATA_W(8), .RES_W(16)) bus ();

  calc_host_seq #(.DATA_W(8), .RES_W(16), .TIMEOUT(T)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total  = 0;
  int passed = 0;
  int starts = 0;

  always @(negedge clk) if (bus.calc_start) starts++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0]  x;
    logic [15:0] res;
    int          s;       // WAIT cycles pronto is still high from before
    int          d;       // WAIT cycle index where fresh pronto rises
    int          hold;    // cycles out_ready is held low in HOLD
    logic [15:0] exp_res;
    logic        exp_err;
    int          exp_wc;  // WAIT cycles until out_valid
  } vec_t;

  vec_t vt[$];

  // Job-level reference: fresh pronto at index d is captured unless the timeout
  // window (T WAIT cycles) closes first.
  task automatic model(input logic [15:0] res, input int d,
                       output logic [15:0] er, output logic ee, output int ewc);
`ifdef CALC_HOST_TIMEOUT_EN
    if (d > T - 1) begin er = 16'h0; ee = 1'b1; ewc = T; end
    else begin er = res; ee = 1'b0; ewc = d + 1; end
`else
    er = res; ee = 1'b0; ewc = d + 1;
`endif
  endtask

  task automatic do_job(input string tag, input vec_t v);
    int          wc;
    bit          done;
    int          st0;
    logic [15:0] r;
    st0 = starts;
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid    = 1'b1;
    bus.in_x        = v.x;
    bus.out_ready   = 1'b0;
    bus.calc_pronto = (v.s > 0);
    step();
    chk({tag, ".start"}, 32'(bus.calc_start), 32'd1);
    chk({tag, ".calc_x"}, 32'(bus.calc_x), 32'(v.x));
    bus.in_valid = 1'b0;
    step();
    wc = 0;
    done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      bus.calc_pronto = (i < v.s) || (i >= v.d);
      bus.calc_result = bus.calc_pronto ? v.res : 16'hDEAD;
      step();
      wc++;
      if (bus.out_valid) done = 1;
    end
    chk({tag, ".done"}, 32'(done), 32'd1);
    chk({tag, ".wait_cycles"}, 32'(wc), 32'(v.exp_wc));
    chk({tag, ".result"}, 32'(bus.out_result), 32'(v.exp_res));
    chk({tag, ".err"}, 32'(bus.out_err), 32'(v.exp_err));
    r = bus.out_result;
    for (int i = 0; i < v.hold; i++) begin
      bus.in_valid = 1'b1;
      bus.in_x     = 8'h77;
      step();
      chk({tag, ".hold_valid"}, 32'(bus.out_valid), 32'd1);
      chk({tag, ".hold_result"}, 32'(bus.out_result), 32'(r));
      chk({tag, ".hold_in_ready"}, 32'(bus.in_ready), 32'd0);
      chk({tag, ".hold_calc_x"}, 32'(bus.calc_x), 32'(v.x));
    end
    bus.out_ready = 1'b1;
    step();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk({tag, ".idle_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, ".idle_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, ".starts"}, 32'(starts - st0), 32'd1);
  endtask

  initial begin
    vec_t v;
    int   st0;
    bit   seen;

    bus.in_valid    = 1'b0;
    bus.in_x        = 8'h00;
    bus.calc_pronto = 1'b0;
    bus.calc_result = 16'h0;
    bus.out_ready   = 1'b0;

    vt.push_back('{8'h2A, 16'h1234, 0, 5, 0, 16'h1234, 1'b0, 6});   // basic
    vt.push_back('{8'h11, 16'h00FF, 2, 5, 0, 16'h00FF, 1'b0, 6});   // stale pronto
    vt.push_back('{8'h3C, 16'hABCD, 0, 2, 10, 16'hABCD, 1'b0, 3});  // backpressure
    vt.push_back('{8'h01, 16'h0003, 0, 1, 0, 16'h0003, 1'b0, 2});   // back-to-back
    vt.push_back('{8'h02, 16'h0006, 0, 1, 0, 16'h0006, 1'b0, 2});
    vt.push_back('{8'h03, 16'h0009, 0, 1, 0, 16'h0009, 1'b0, 2});
`ifdef CALC_HOST_TIMEOUT_EN
    vt.push_back('{8'h44, 16'h5555, 0, 50, 0, 16'h0000, 1'b1, T});  // never pronto
    vt.push_back('{8'h45, 16'h6666, 0, T - 1, 0, 16'h6666, 1'b0, T}); // pronto on last cycle
`endif

    // reset state
    repeat (2) step();
    chk("rst.in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst.busy", 32'(bus.busy), 32'd0);
    chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst.start", 32'(bus.calc_start), 32'd0);
    chk("rst.calc_x", 32'(bus.calc_x), 32'd0);
    chk("rst.out_result", 32'(bus.out_result), 32'd0);
    chk("rst.out_err", 32'(bus.out_err), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst.in_ready", 32'(bus.in_ready), 32'd1);

    foreach (vt[i]) do_job($sformatf("vec%0d", i), vt[i]);

    // reset in the middle of WAIT abandons the job
    st0 = starts;
    bus.in_valid = 1'b1;
    bus.in_x     = 8'h55;
    step();
    bus.in_valid = 1'b0;
    repeat (3) step();
    chk("midrst.busy_before", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst.busy_during", 32'(bus.busy), 32'd0);
    chk("midrst.in_ready_during", 32'(bus.in_ready), 32'd0);
    step();
    rst = 1'b0;
    #1;
    chk("midrst.busy", 32'(bus.busy), 32'd0);
    chk("midrst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst.start", 32'(bus.calc_start), 32'd0);
    chk("midrst.calc_x", 32'(bus.calc_x), 32'd0);
    bus.calc_pronto = 1'b1;
    bus.calc_result = 16'hBEEF;
    seen = 0;
    repeat (5) begin
      step();
      if (bus.out_valid || bus.busy) seen = 1;
    end
    chk("midrst.late_pronto_ignored", 32'(seen), 32'd0);
    chk("midrst.starts", 32'(starts - st0), 32'd1);

    // random jobs vs job-level model
    for (int n = 0; n < 40; n++) begin
      v.x    = 8'($urandom);
      v.res  = 16'($urandom);
      v.s    = int'($urandom_range(0, 2));
      v.d    = v.s + 1 + int'($urandom_range(0, 9));
      v.hold = int'($urandom_range(0, 3));
      model(v.res, v.d, v.exp_res, v.exp_err, v.exp_wc);
      do_job($sformatf("rnd%0d", n), v);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
